// File: rtl/nmr_bstrm_pls_cnt.sv
// -----------------------------------------------------------------------------
// nmr_bstrm_pls_cnt
//
// Sequencer for the NMR bitstream pulse generator. It fetches instruction words
// from a synchronous SRAM with 2-cycle read latency. For each word it latches
// the initial-delay, pulse-width and post-pulse-delay fields. It then fires a
// one-cycle BT_START at the bitstream generator and waits for BT_DONE. After
// that it decodes the command bits: LOOP_START, LOOP_END and STOP. It supports
// one loop level.
//
// Ports
//   CLK          : clock, all logic on rising edge
//   RST          : asynchronous active-low reset
//   START        : sequence start request (rising edge detected in IDLE)
//   DONE         : one-cycle pulse when the sequence completes
//   SRAM_ADDR    : instruction address
//   SRAM_CS      : SRAM chip select (high in RD_ADDR / RD_WAIT / LATCH)
//   SRAM_CLKEN   : SRAM clock enable (same timing as SRAM_CS)
//   SRAM_WR      : write strobe, constant 0
//   SRAM_RD_DAT  : instruction word read from SRAM
//   SRAM_WR_DAT  : write data, constant 0
//   SRAM_BYTEEN  : byte enables, constant all-ones
//   BT_START     : one-cycle start pulse to the bitstream generator
//   BT_DONE      : bitstream generator completion (level, sampled in BT_WAIT)
//   idly_reg     : latched initial delay
//   pls_reg      : latched pulse width
//   edly_reg     : latched post-pulse delay
// -----------------------------------------------------------------------------
module nmr_bstrm_pls_cnt #(
    parameter int IDLY_WIDTH        = 32,
    parameter int PLS_WIDTH         = 32,
    parameter int EDLY_WIDTH        = 32,
    parameter int CNT_WIDTH         = 32,
    parameter int CMD_WIDTH         = 8,
    parameter int LOOP_WIDTH        = 16,
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    output logic                         DONE,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
    output logic                         BT_START,
    input  logic                         BT_DONE,
    output logic [IDLY_WIDTH-1:0]        idly_reg,
    output logic [PLS_WIDTH-1:0]         pls_reg,
    output logic [EDLY_WIDTH-1:0]        edly_reg
);

    // Field positions inside the instruction word: the delay/pulse fields are
    // packed from the top, the loop count starts at bit 16, the command at bit 0.
    localparam int IDLY_LSB = SRAM_DAT_WIDTH - IDLY_WIDTH;
    localparam int PLS_LSB  = IDLY_LSB - PLS_WIDTH;
    localparam int EDLY_LSB = PLS_LSB - EDLY_WIDTH;
    localparam int LOOP_LSB = 16;

    localparam logic [LOOP_WIDTH-1:0]      LOOP_ONE = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE = {{(SRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_MAX = {SRAM_ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_LATCH   = 3'd3,
        ST_BT_GO   = 3'd4,
        ST_BT_WAIT = 3'd5,
        ST_DECODE  = 3'd6,
        ST_FINISH  = 3'd7
    } state_t;

    state_t                      state_r;
    state_t                      state_nx_s;

    logic                        start_d_r;
    logic                        start_rise_s;

    logic [SRAM_ADDR_WIDTH-1:0]  addr_r;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_nx_s;
    logic [SRAM_ADDR_WIDTH-1:0]  loop_addr_r;
    logic [SRAM_ADDR_WIDTH-1:0]  loop_addr_nx_s;
    logic [LOOP_WIDTH-1:0]       loop_cnt_r;
    logic [LOOP_WIDTH-1:0]       loop_cnt_nx_s;
    logic                        jumped_r;
    logic                        jumped_nx_s;

    logic [2:0]                  cmd_r;
    logic [LOOP_WIDTH-1:0]       loop_fld_r;

    logic                        ls_take_s;
    logic [LOOP_WIDTH-1:0]       eff_cnt_s;
    logic [SRAM_ADDR_WIDTH-1:0]  eff_addr_s;

    logic                        cs_r;
    logic                        bt_start_r;
    logic                        done_r;
    logic [IDLY_WIDTH-1:0]       idly_r;
    logic [PLS_WIDTH-1:0]        pls_r;
    logic [EDLY_WIDTH-1:0]       edly_r;

    // Reserved parameter and ignored word bits (command bits above STOP and
    // the spare byte) are gathered here so they are visibly unused.
    logic                        unused_s;
    assign unused_s = ^{SRAM_RD_DAT[LOOP_LSB-1:3], (CNT_WIDTH > 0)};

    assign start_rise_s = START & ~start_d_r;

    // LOOP_START arms the loop only when its word is reached sequentially.
    // On a loop-back jump the word is re-entered with jumped_r set, so the
    // counter is not reloaded and the loop terminates. This is also what lets
    // a word carrying both LOOP_START and LOOP_END repeat itself.
    assign ls_take_s  = cmd_r[0] & ~jumped_r;
    assign eff_cnt_s  = ls_take_s ? loop_fld_r : loop_cnt_r;
    assign eff_addr_s = ls_take_s ? addr_r     : loop_addr_r;

    // Next-state and datapath next-value logic
    always_comb begin
        state_nx_s     = state_r;
        addr_nx_s      = addr_r;
        loop_addr_nx_s = loop_addr_r;
        loop_cnt_nx_s  = loop_cnt_r;
        jumped_nx_s    = jumped_r;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    addr_nx_s      = {SRAM_ADDR_WIDTH{1'b0}};
                    loop_addr_nx_s = {SRAM_ADDR_WIDTH{1'b0}};
                    loop_cnt_nx_s  = {LOOP_WIDTH{1'b0}};
                    jumped_nx_s    = 1'b0;
                    state_nx_s     = ST_RD_ADDR;
                end else begin
                    state_nx_s     = ST_IDLE;
                end
            end
            ST_RD_ADDR: state_nx_s = ST_RD_WAIT;
            ST_RD_WAIT: state_nx_s = ST_LATCH;
            ST_LATCH:   state_nx_s = ST_BT_GO;
            ST_BT_GO:   state_nx_s = ST_BT_WAIT;
            ST_BT_WAIT: begin
                if (BT_DONE) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_BT_WAIT;
                end
            end
            ST_DECODE: begin
                loop_cnt_nx_s  = eff_cnt_s;
                loop_addr_nx_s = eff_addr_s;
                if (cmd_r[1] && (eff_cnt_s > LOOP_ONE)) begin
                    loop_cnt_nx_s = eff_cnt_s - LOOP_ONE;
                    addr_nx_s     = eff_addr_s;
                    jumped_nx_s   = 1'b1;
                    state_nx_s    = ST_RD_ADDR;
                end else begin
                    jumped_nx_s = 1'b0;
                    if (cmd_r[2] || (addr_r == ADDR_MAX)) begin
                        state_nx_s = ST_FINISH;
                    end else begin
                        addr_nx_s  = addr_r + ADDR_ONE;
                        state_nx_s = ST_RD_ADDR;
                    end
                end
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State, sequencing registers and registered control outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            start_d_r   <= 1'b0;
            addr_r      <= {SRAM_ADDR_WIDTH{1'b0}};
            loop_addr_r <= {SRAM_ADDR_WIDTH{1'b0}};
            loop_cnt_r  <= {LOOP_WIDTH{1'b0}};
            jumped_r    <= 1'b0;
            cs_r        <= 1'b0;
            bt_start_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            start_d_r   <= START;
            addr_r      <= addr_nx_s;
            loop_addr_r <= loop_addr_nx_s;
            loop_cnt_r  <= loop_cnt_nx_s;
            jumped_r    <= jumped_nx_s;
            // Outputs decoded from the next state so they align with the state
            cs_r        <= (state_nx_s == ST_RD_ADDR) || (state_nx_s == ST_RD_WAIT) ||
                           (state_nx_s == ST_LATCH);
            bt_start_r  <= (state_nx_s == ST_BT_GO);
            done_r      <= (state_nx_s == ST_FINISH);
        end
    end

    // Instruction field capture when the SRAM word is valid
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idly_r     <= {IDLY_WIDTH{1'b0}};
            pls_r      <= {PLS_WIDTH{1'b0}};
            edly_r     <= {EDLY_WIDTH{1'b0}};
            cmd_r      <= 3'b000;
            loop_fld_r <= {LOOP_WIDTH{1'b0}};
        end else if (state_r == ST_LATCH) begin
            idly_r     <= SRAM_RD_DAT[IDLY_LSB +: IDLY_WIDTH];
            pls_r      <= SRAM_RD_DAT[PLS_LSB  +: PLS_WIDTH];
            edly_r     <= SRAM_RD_DAT[EDLY_LSB +: EDLY_WIDTH];
            cmd_r      <= SRAM_RD_DAT[2:0];
            loop_fld_r <= SRAM_RD_DAT[LOOP_LSB +: LOOP_WIDTH];
        end else begin
            idly_r     <= idly_r;
            pls_r      <= pls_r;
            edly_r     <= edly_r;
            cmd_r      <= cmd_r;
            loop_fld_r <= loop_fld_r;
        end
    end

    assign DONE        = done_r;
    assign SRAM_ADDR   = addr_r;
    assign SRAM_CS     = cs_r;
    assign SRAM_CLKEN  = cs_r;
    assign SRAM_WR     = 1'b0;
    assign SRAM_WR_DAT = {SRAM_DAT_WIDTH{1'b0}};
    assign SRAM_BYTEEN = {SRAM_BYTEEN_WIDTH{1'b1}};
    assign BT_START    = bt_start_r;
    assign idly_reg    = idly_r;
    assign pls_reg     = pls_r;
    assign edly_reg    = edly_r;

endmodule

// File: tb/tb_nmr_bstrm_pls_cnt.sv
// -----------------------------------------------------------------------------
// tb_nmr_bstrm_pls_cnt
//
// Directed bench for nmr_bstrm_pls_cnt. It uses a 2-cycle-latency SRAM model
// and a bitstream-generator responder with either a programmable delay or a
// held-high BT_DONE. A negedge monitor records BT_START addresses, DONE
// pulses, chip-select cycles and the constant SRAM write-side outputs.
// -----------------------------------------------------------------------------
module tb_nmr_bstrm_pls_cnt;

    logic         CLK;
    logic         RST;
    logic         START;
    logic         DONE;
    logic [7:0]   SRAM_ADDR;
    logic         SRAM_CS;
    logic         SRAM_CLKEN;
    logic         SRAM_WR;
    logic [127:0] SRAM_RD_DAT;
    logic [127:0] SRAM_WR_DAT;
    logic [15:0]  SRAM_BYTEEN;
    logic         BT_START;
    logic         BT_DONE;
    logic [31:0]  idly_reg;
    logic [31:0]  pls_reg;
    logic [31:0]  edly_reg;

    nmr_bstrm_pls_cnt dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .DONE        (DONE),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_CS     (SRAM_CS),
        .SRAM_CLKEN  (SRAM_CLKEN),
        .SRAM_WR     (SRAM_WR),
        .SRAM_RD_DAT (SRAM_RD_DAT),
        .SRAM_WR_DAT (SRAM_WR_DAT),
        .SRAM_BYTEEN (SRAM_BYTEEN),
        .BT_START    (BT_START),
        .BT_DONE     (BT_DONE),
        .idly_reg    (idly_reg),
        .pls_reg     (pls_reg),
        .edly_reg    (edly_reg)
    );

    int n_cmp = 0;
    int n_err = 0;

    int bt_cnt   = 0;
    int done_cnt = 0;
    int cs_cyc   = 0;
    int tie_err  = 0;
    logic [7:0] trace [$];

    int bt_delay = 8;
    bit bt_hold  = 1'b0;

    logic [127:0] mem [0:255];
    logic [127:0] p1;
    logic [127:0] p2;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // SRAM model: address registered with CS, data valid two edges later
    always @(posedge CLK) begin
        if (SRAM_CS) p1 <= mem[SRAM_ADDR];
        p2 <= p1;
    end
    assign SRAM_RD_DAT = p2;

    // Bitstream generator responder
    initial begin
        BT_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            if (bt_hold) begin
                BT_DONE = 1'b1;
            end else if (BT_START) begin
                BT_DONE = 1'b0;
                repeat (bt_delay - 1) @(negedge CLK);
                BT_DONE = 1'b1;
                @(negedge CLK);
                BT_DONE = 1'b0;
            end else begin
                BT_DONE = 1'b0;
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge CLK);
            if (BT_START === 1'b1) begin
                bt_cnt++;
                trace.push_back(SRAM_ADDR);
            end
            if (DONE === 1'b1) done_cnt++;
            if (SRAM_CS === 1'b1) cs_cyc++;
            if (SRAM_WR !== 1'b0 || SRAM_WR_DAT !== 128'h0 || SRAM_BYTEEN !== 16'hFFFF)
                tie_err++;
        end
    end

    function automatic logic [127:0] mk(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] e, input logic [15:0] lp,
                                        input logic [7:0] c);
        return {i, p, e, lp, 8'h00, c};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 128'h0;
    endtask

    task automatic run_seq(input int hold, output bit ok);
        int cyc;
        @(negedge CLK);
        bt_cnt   = 0;
        done_cnt = 0;
        cs_cyc   = 0;
        trace.delete();
        START = 1'b1;
        repeat (hold) @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
        end
        ok = (done_cnt > 0);
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset();
        START = 1'b0;
        RST   = 1'b1;
        #3 RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", DONE); end
        n_cmp++; if (BT_START !== 1'b0) begin n_err++; $display("FAIL rst_bt_start: got %b expected 0", BT_START); end
        n_cmp++; if (SRAM_CS !== 1'b0 || SRAM_CLKEN !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b/%b expected 0/0", SRAM_CS, SRAM_CLKEN); end
        n_cmp++; if (SRAM_ADDR !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", SRAM_ADDR); end
        n_cmp++; if (idly_reg !== 32'h0 || pls_reg !== 32'h0 || edly_reg !== 32'h0) begin n_err++; $display("FAIL rst_regs: got %0d/%0d/%0d expected 0/0/0", idly_reg, pls_reg, edly_reg); end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_single();
        bit ok;
        clear_mem();
        mem[0] = mk(32'd15, 32'd10, 32'd20, 16'd0, 8'h04);
        bt_hold = 1'b0; bt_delay = 8;
        run_seq(1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: got no DONE expected DONE"); end
        n_cmp++; if (bt_cnt !== 1) begin n_err++; $display("FAIL single_bt_cnt: got %0d expected 1", bt_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (idly_reg !== 32'd15 || pls_reg !== 32'd10 || edly_reg !== 32'd20) begin n_err++; $display("FAIL single_regs: got %0d/%0d/%0d expected 15/10/20", idly_reg, pls_reg, edly_reg); end
        n_cmp++; if (SRAM_ADDR !== 8'd0) begin n_err++; $display("FAIL single_addr: got %0d expected 0", SRAM_ADDR); end
        n_cmp++; if (cs_cyc !== 3) begin n_err++; $display("FAIL single_cs_cycles: got %0d expected 3", cs_cyc); end
    endtask

    task automatic test_loop();
        bit ok;
        logic [7:0] exp_tr [7];
        exp_tr = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd2};
        clear_mem();
        mem[0] = mk(32'd1, 32'd2, 32'd3, 16'd3, 8'h01);
        mem[1] = mk(32'd4, 32'd5, 32'd6, 16'd0, 8'h02);
        mem[2] = mk(32'd7, 32'd8, 32'd9, 16'd0, 8'h04);
        bt_hold = 1'b0; bt_delay = 3;
        run_seq(1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL loop_timeout: got no DONE expected DONE"); end
        n_cmp++; if (bt_cnt !== 7) begin n_err++; $display("FAIL loop_bt_cnt: got %0d expected 7", bt_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL loop_done_cnt: got %0d expected 1", done_cnt); end
        if (trace.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++; if (trace[i] !== exp_tr[i]) begin n_err++; $display("FAIL loop_trace[%0d]: got %0d expected %0d", i, trace[i], exp_tr[i]); end
            end
        end else begin
            n_cmp++; n_err++; $display("FAIL loop_trace_len: got %0d expected 7", trace.size());
        end
        n_cmp++; if (idly_reg !== 32'd7 || pls_reg !== 32'd8 || edly_reg !== 32'd9) begin n_err++; $display("FAIL loop_regs: got %0d/%0d/%0d expected 7/8/9", idly_reg, pls_reg, edly_reg); end
        n_cmp++; if (cs_cyc !== 21) begin n_err++; $display("FAIL loop_cs_cycles: got %0d expected 21", cs_cyc); end
    endtask

    task automatic test_self_loop();
        bit ok;
        int bad;
        clear_mem();
        mem[0] = mk(32'd11, 32'd12, 32'd13, 16'd3, 8'h07);
        mem[1] = mk(32'd99, 32'd99, 32'd99, 16'd0, 8'h04);
        bt_hold = 1'b0; bt_delay = 2;
        run_seq(1, ok);
        bad = 0;
        foreach (trace[i]) if (trace[i] !== 8'd0) bad++;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL self_timeout: got no DONE expected DONE"); end
        n_cmp++; if (bt_cnt !== 3) begin n_err++; $display("FAIL self_bt_cnt: got %0d expected 3", bt_cnt); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL self_trace: got %0d non-zero addresses expected 0", bad); end
        n_cmp++; if (idly_reg !== 32'd11) begin n_err++; $display("FAIL self_idly: got %0d expected 11", idly_reg); end
    endtask

    task automatic test_loop_single_pass();
        bit ok;
        for (int lp = 0; lp < 2; lp++) begin
            clear_mem();
            mem[0] = mk(32'd1, 32'd1, 32'd1, lp[15:0], 8'h03);
            mem[1] = mk(32'd2, 32'd2, 32'd2, 16'd0, 8'h04);
            bt_hold = 1'b0; bt_delay = 2;
            run_seq(1, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL onepass%0d_timeout: got no DONE expected DONE", lp); end
            n_cmp++; if (bt_cnt !== 2) begin n_err++; $display("FAIL onepass%0d_bt_cnt: got %0d expected 2", lp, bt_cnt); end
            if (trace.size() == 2) begin
                n_cmp++; if (trace[0] !== 8'd0 || trace[1] !== 8'd1) begin n_err++; $display("FAIL onepass%0d_trace: got %0d,%0d expected 0,1", lp, trace[0], trace[1]); end
            end else begin
                n_cmp++; n_err++; $display("FAIL onepass%0d_trace_len: got %0d expected 2", lp, trace.size());
            end
        end
    endtask

    task automatic test_bt_hold();
        bit ok;
        clear_mem();
        mem[0] = mk(32'd5, 32'd6, 32'd7, 16'd0, 8'h00);
        mem[1] = mk(32'd8, 32'd9, 32'd10, 16'd0, 8'h04);
        bt_hold = 1'b1;
        run_seq(1, ok);
        bt_hold = 1'b0;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_timeout: got no DONE expected DONE"); end
        n_cmp++; if (bt_cnt !== 2) begin n_err++; $display("FAIL hold_bt_cnt: got %0d expected 2", bt_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL hold_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (edly_reg !== 32'd10) begin n_err++; $display("FAIL hold_edly: got %0d expected 10", edly_reg); end
    endtask

    task automatic test_start_held();
        bit ok;
        clear_mem();
        mem[0] = mk(32'd3, 32'd4, 32'd5, 16'd0, 8'h04);
        bt_hold = 1'b0; bt_delay = 8;
        run_seq(300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL held_timeout: got no DONE expected DONE"); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL held_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (bt_cnt !== 1) begin n_err++; $display("FAIL held_bt_cnt: got %0d expected 1", bt_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        clear_mem();
        mem[0] = mk(32'd1, 32'd2, 32'd3, 16'd0, 8'h00);
        mem[1] = mk(32'd21, 32'd22, 32'd23, 16'd0, 8'h04);
        bt_hold = 1'b0; bt_delay = 50;
        @(negedge CLK);
        bt_cnt = 0; done_cnt = 0; trace.delete();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (bt_cnt < 2 && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
        end
        n_cmp++; if (bt_cnt !== 2) begin n_err++; $display("FAIL mid_reach_wait: got %0d BT_START expected 2", bt_cnt); end
        repeat (3) @(negedge CLK);
        n_cmp++; if (SRAM_ADDR !== 8'd1 || idly_reg !== 32'd21) begin n_err++; $display("FAIL mid_pre_state: got addr %0d idly %0d expected 1/21", SRAM_ADDR, idly_reg); end
        #2 RST = 1'b0;
        #1;
        n_cmp++; if (SRAM_ADDR !== 8'd0 || DONE !== 1'b0 || BT_START !== 1'b0 || SRAM_CS !== 1'b0 || SRAM_CLKEN !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: got addr %0d done %b bt %b cs %b clken %b expected 0", SRAM_ADDR, DONE, BT_START, SRAM_CS, SRAM_CLKEN); end
        n_cmp++; if (idly_reg !== 32'h0 || pls_reg !== 32'h0 || edly_reg !== 32'h0) begin n_err++; $display("FAIL mid_rst_regs: got %0d/%0d/%0d expected 0/0/0", idly_reg, pls_reg, edly_reg); end
        @(negedge CLK);
        RST = 1'b1;
        repeat (60) @(negedge CLK);
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
        clear_mem();
        mem[0] = mk(32'd31, 32'd32, 32'd33, 16'd0, 8'h04);
        bt_delay = 8;
        run_seq(1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_restart_timeout: got no DONE expected DONE"); end
        if (trace.size() == 1) begin
            n_cmp++; if (trace[0] !== 8'd0) begin n_err++; $display("FAIL mid_restart_addr: got %0d expected 0", trace[0]); end
        end else begin
            n_cmp++; n_err++; $display("FAIL mid_restart_len: got %0d expected 1", trace.size());
        end
        n_cmp++; if (idly_reg !== 32'd31) begin n_err++; $display("FAIL mid_restart_idly: got %0d expected 31", idly_reg); end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        clear_mem();
        bt_hold = 1'b1;
        run_seq(1, ok);
        bt_hold = 1'b0;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got no DONE expected DONE"); end
        n_cmp++; if (bt_cnt !== 256) begin n_err++; $display("FAIL wrap_bt_cnt: got %0d expected 256", bt_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL wrap_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (SRAM_ADDR !== 8'd255) begin n_err++; $display("FAIL wrap_addr: got %0d expected 255", SRAM_ADDR); end
        if (trace.size() == 256) begin
            n_cmp++; if (trace[0] !== 8'd0 || trace[255] !== 8'd255) begin n_err++; $display("FAIL wrap_trace_ends: got %0d,%0d expected 0,255", trace[0], trace[255]); end
        end else begin
            n_cmp++; n_err++; $display("FAIL wrap_trace_len: got %0d expected 256", trace.size());
        end
    endtask

    task automatic test_ties();
        n_cmp++; if (tie_err !== 0) begin n_err++; $display("FAIL tie_outputs: got %0d bad cycles expected 0", tie_err); end
    endtask

    initial begin
        START = 1'b0;
        RST   = 1'b1;
        clear_mem();
        test_reset();
        test_single();
        test_loop();
        test_self_loop();
        test_loop_single_pass();
        test_bt_hold();
        test_start_held();
        test_reset_mid();
        test_addr_wrap();
        test_ties();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nmr_bstrm_pls_cnt.md
NMR_BSTRM_PLS_CNT -- requirements
Module: nmr_bstrm_pls_cnt

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IDLY_WIDTH, 32, initial-delay field width
- PLS_WIDTH, 32, pulse-width field width
- EDLY_WIDTH, 32, post-pulse delay field width
- CNT_WIDTH, 32, reserved; no functional effect
- CMD_WIDTH, 8, command field width
- LOOP_WIDTH, 16, loop-count field width
- SRAM_ADDR_WIDTH, 8, SRAM address width
- SRAM_DAT_WIDTH, 128, SRAM word width
- SRAM_BYTEEN_WIDTH, 16, SRAM byte-enable width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single clock; all logic on its rising edge
- RST, in, 1, asynchronous, active-low reset
- START, in, 1, sequence start request (rising edge)
- DONE, out, 1, one-cycle sequence-complete pulse
- SRAM_ADDR, out, SRAM_ADDR_WIDTH, instruction address
- SRAM_CS, out, 1, SRAM chip select
- SRAM_CLKEN, out, 1, SRAM clock enable
- SRAM_WR, out, 1, SRAM write strobe; tied 0
- SRAM_RD_DAT, in, SRAM_DAT_WIDTH, instruction word
- SRAM_WR_DAT, out, SRAM_DAT_WIDTH, tied 0
- SRAM_BYTEEN, out, SRAM_BYTEEN_WIDTH, tied all-ones
- BT_START, out, 1, one-cycle start pulse to the bitstream generator
- BT_DONE, in, 1, bitstream-generator completion
- idly_reg, out, IDLY_WIDTH, latched initial delay
- pls_reg, out, PLS_WIDTH, latched pulse width
- edly_reg, out, EDLY_WIDTH, latched post-pulse delay

Function
REQ-003 Instruction word fields: [127:96] idly, [95:64] pls, [63:32] edly, [31:16] loop count, [7:0] command; bits [15:8] ignored.
REQ-004 Command bits: bit0 LOOP_START, bit1 LOOP_END, bit2 STOP; other bits ignored; cmd 0 = plain step.
REQ-005 States: IDLE, RD_ADDR, RD_WAIT, LATCH, BT_GO, BT_WAIT, DECODE, FINISH.
REQ-006 IDLE: a START rising edge (registered START low, current START high) clears address to 0 and the loop state, then goes to RD_ADDR; START is ignored in every other state.
REQ-007 SRAM_CS and SRAM_CLKEN are high in RD_ADDR, RD_WAIT and LATCH only; SRAM read latency is 2 cycles (RD_ADDR, RD_WAIT), and the word is sampled in LATCH.
REQ-008 LATCH: load idly_reg, pls_reg and edly_reg plus internal cmd/loop registers; outputs hold until the next LATCH or reset.
REQ-009 BT_GO: BT_START is high for exactly one cycle, then the FSM enters BT_WAIT.
REQ-010 BT_WAIT: wait until BT_DONE is sampled high (level), then go to DECODE; BT_DONE is ignored in other states.
REQ-011 DECODE order:
- LOOP_START: store the current address as the loop address and load the loop counter with the loop field; evaluated before LOOP_END of the same word, so a word with both bits repeats itself.
- LOOP_END: if counter > 1, decrement it and jump to the loop address; otherwise fall through.
- On fall-through: STOP goes to FINISH; otherwise increment the address and go to RD_ADDR.
REQ-012 A loop field of 0 or 1 gives a single pass. One loop level only; a new LOOP_START overwrites the loop address and counter.
REQ-013 Address wrap: fall-through at address 2^SRAM_ADDR_WIDTH-1 without STOP goes to FINISH; the address does not wrap.
REQ-014 FINISH: DONE is high for one cycle, then the FSM returns to IDLE.

Reset
REQ-015 RST low asynchronously forces IDLE, address 0, DONE=0, BT_START=0, SRAM_CS=0, SRAM_CLKEN=0, idly/pls/edly regs=0, and the loop counter and loop address to 0; this also applies mid-sequence, with no DONE generated.
REQ-016 After RST rises, the first rising edge of START is the earliest accepted start.

Verification
REQ-017 Single word {idly 15, pls 10, edly 20, cmd STOP}, BT_DONE 8 cycles after BT_START -> one BT_START; regs = 15/10/20; DONE pulses once; SRAM_ADDR stays 0.
REQ-018 addr0 cmd LOOP_START loop 3; addr1 cmd LOOP_END; addr2 cmd STOP -> address trace 0,1,0,1,0,1,2; 7 BT_START pulses; then DONE.
REQ-019 Word with cmd = LOOP_START|LOOP_END|STOP, loop 3 -> 3 BT_START pulses at address 0, then DONE.
REQ-020 BT_DONE held high before BT_START -> BT_START is still issued once per instruction.
REQ-021 RST low while in BT_WAIT -> all outputs take reset values immediately; a later START restarts from address 0.
REQ-022 START held high for many cycles -> exactly one sequence runs; SRAM_WR=0, SRAM_WR_DAT=0 and SRAM_BYTEEN=all-ones at all times.
